// File: rtl/ram_stack_ctrl.sv
// ram_stack_ctrl -- LIFO byte stack kept in an external 256x8 single-port RAM
// whose read port has one cycle of registered latency.
//
// Optional feature macro: STACK_PEEK_EN adds the PEEK input, which reads the
// top of stack through the pop read path without changing SP.
//
// Ports
//   CLK, RST         clock; synchronous active-high reset
//   PUSH, POP        stack commands, sampled only while idle
//   PEEK             top-of-stack read (only with STACK_PEEK_EN)
//   Din              byte to push
//   Dout, DVALID     last popped/peeked byte and its one-cycle "new" pulse
//   FULL, EMPTY      combinational from the stack pointer
//   BUSY             a read is in flight; commands are ignored
//   ERR              one-cycle pulse after a push-while-full or a
//                    pop/peek-while-empty
//   RAM_*            RAM Addr/Din/WE/EN/RST and the RAM's registered Dout
//   dbg_state        FSM state (IDLE=0, RD_WAIT=1, CAPTURE=2)
//   dbg_sp           stack pointer (number of stored bytes)
//
// Command semantics: a command is accepted in the cycle it is presented
// while BUSY=0. A push completes in that cycle. A pop or peek is answered
// by a one-cycle DVALID pulse three cycles after the accept cycle. The
// block never stalls the requester. Outside IDLE, any command is dropped
// without raising ERR.
module ram_stack_ctrl #(
    parameter int DEPTH = 256
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PUSH,
    input  logic       POP,
`ifdef STACK_PEEK_EN
    input  logic       PEEK,
`endif
    input  logic [7:0] Din,
    output logic [7:0] Dout,
    output logic       DVALID,
    output logic       FULL,
    output logic       EMPTY,
    output logic       BUSY,
    output logic       ERR,
    output logic [7:0] RAM_ADDR,
    output logic [7:0] RAM_DIN,
    output logic       RAM_WE,
    output logic       RAM_EN,
    output logic       RAM_RST,
    input  logic [7:0] RAM_DOUT,
    output logic [1:0] dbg_state,
    output logic [8:0] dbg_sp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    state_t     state;
    logic [8:0] sp;

    logic       peek_req;
    logic       idle_cmd;
    logic       do_push;
    logic       do_pop;
    logic       do_peek;
    logic       bad_cmd;
    logic [7:0] top_addr;

`ifdef STACK_PEEK_EN
    assign peek_req = PEEK;
`else
    assign peek_req = 1'b0;
`endif

    assign FULL      = (sp == DEPTH_W);
    assign EMPTY     = (sp == 9'd0);
    assign BUSY      = (state != IDLE);
    assign RAM_RST   = RST;
    assign dbg_state = state;
    assign dbg_sp    = sp;

    // Commands are decoded only in IDLE and only when reset is low, so that
    // reset suppresses any RAM access in the same cycle.
    // Priority is PUSH, then POP, then PEEK.
    assign idle_cmd = (state == IDLE) && !RST;
    assign do_push  = idle_cmd && PUSH && !FULL;
    assign do_pop   = idle_cmd && !PUSH && POP && !EMPTY;
    assign do_peek  = idle_cmd && !PUSH && !POP && peek_req && !EMPTY;
    assign bad_cmd  = idle_cmd && ((PUSH && FULL) ||
                                   (!PUSH && POP && EMPTY) ||
                                   (!PUSH && !POP && peek_req && EMPTY));

    // SP[7:0]-1 is still the correct top address when SP==256, because it
    // wraps to 0 - 1 = 255.
    assign top_addr = sp[7:0] - 8'd1;

    always_comb begin
        RAM_EN   = 1'b0;
        RAM_WE   = 1'b0;
        RAM_ADDR = 8'h00;
        RAM_DIN  = 8'h00;
        if (do_push) begin
            RAM_EN   = 1'b1;
            RAM_WE   = 1'b1;
            RAM_ADDR = sp[7:0];
            RAM_DIN  = Din;
        end else if (do_pop || do_peek) begin
            RAM_EN   = 1'b1;
            RAM_ADDR = top_addr;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            sp     <= 9'd0;
            Dout   <= 8'h00;
            DVALID <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            DVALID <= 1'b0;
            ERR    <= bad_cmd;
            case (state)
                IDLE: begin
                    if (do_push) begin
                        sp <= sp + 9'd1;
                    end else if (do_pop) begin
                        sp    <= sp - 9'd1;
                        state <= RD_WAIT;
                    end else if (do_peek) begin
                        state <= RD_WAIT;
                    end
                end
                // The RAM registers the read at the end of the accept cycle.
                // Its output then stays stable while EN is low.
                RD_WAIT: state <= CAPTURE;
                CAPTURE: begin
                    Dout   <= RAM_DOUT;
                    DVALID <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stack_ctrl.sv
// Testbench for ram_stack_ctrl (DEPTH=4). A 256x8 RAM model with a
// registered read port is attached to the RAM pins. A stack-queue reference
// model predicts every output each cycle. Directed sequences add literal
// expectations on top of the model.
module tb_ram_stack_ctrl;

    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST  = 1'b1;
    logic       PUSH = 1'b0;
    logic       POP  = 1'b0;
    logic       PEEK = 1'b0;
    logic [7:0] Din  = 8'h00;

    logic [7:0] Dout;
    logic       DVALID, FULL, EMPTY, BUSY, ERR;
    logic [7:0] RAM_ADDR, RAM_DIN, RAM_DOUT;
    logic       RAM_WE, RAM_EN, RAM_RST;
    logic [1:0] dbg_state;
    logic [8:0] dbg_sp;

    ram_stack_ctrl #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .PUSH(PUSH), .POP(POP),
`ifdef STACK_PEEK_EN
        .PEEK(PEEK),
`endif
        .Din(Din), .Dout(Dout), .DVALID(DVALID),
        .FULL(FULL), .EMPTY(EMPTY), .BUSY(BUSY), .ERR(ERR),
        .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN), .RAM_WE(RAM_WE),
        .RAM_EN(RAM_EN), .RAM_RST(RAM_RST), .RAM_DOUT(RAM_DOUT),
        .dbg_state(dbg_state), .dbg_sp(dbg_sp)
    );

    // ---------------- RAM model ----------------
    logic [7:0] mem [256];
    logic [7:0] ram_q = 8'h00;
    assign RAM_DOUT = ram_q;

    always @(posedge CLK) begin
        if (RAM_RST) ram_q <= 8'h00;
        else if (RAM_EN) begin
            if (RAM_WE) mem[RAM_ADDR] <= RAM_DIN;
            else        ram_q <= mem[RAM_ADDR];
        end
    end

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The stack is a queue. busy_left counts the cycles still to wait before
    // an outstanding read delivers pend.
    logic [7:0] stk [$];
    int         busy_left = 0;
    logic [7:0] pend      = 8'h00;
    logic [7:0] m_dout    = 8'h00;
    logic       m_dvalid  = 1'b0;
    logic       m_err     = 1'b0;
    bit         model_on  = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            stk.delete();
            busy_left = 0;
            m_dout    = 8'h00;
            m_dvalid  = 1'b0;
            m_err     = 1'b0;
            model_on  = 1'b1;
        end else begin
            m_dvalid = 1'b0;
            m_err    = 1'b0;
            if (busy_left == 2) busy_left = 1;
            else if (busy_left == 1) begin
                busy_left = 0;
                m_dout    = pend;
                m_dvalid  = 1'b1;
            end else if (PUSH) begin
                if (stk.size() < DEPTH) stk.push_back(Din);
                else m_err = 1'b1;
            end else if (POP) begin
                if (stk.size() > 0) begin pend = stk.pop_back(); busy_left = 2; end
                else m_err = 1'b1;
            end else if (PEEK) begin
                if (stk.size() > 0) begin pend = stk[$]; busy_left = 2; end
                else m_err = 1'b1;
            end
        end
    end

    // Compare every output on the falling edge.
    always @(negedge CLK) begin
        if (model_on) begin
            logic       e_en, e_we;
            logic [7:0] e_addr, e_din;
            int         n;
            n = stk.size();
            e_en = 1'b0; e_we = 1'b0; e_addr = 8'h00; e_din = 8'h00;
            if (!RST && busy_left == 0) begin
                if (PUSH) begin
                    if (n < DEPTH) begin e_en = 1'b1; e_we = 1'b1; e_addr = 8'(n); e_din = Din; end
                end else if (POP || PEEK) begin
                    if (n > 0) begin e_en = 1'b1; e_addr = 8'(n - 1); end
                end
            end
            chk("m_dout",   Dout,     m_dout);
            chk("m_dvalid", DVALID,   m_dvalid);
            chk("m_err",    ERR,      m_err);
            chk("m_full",   FULL,     (n == DEPTH));
            chk("m_empty",  EMPTY,    (n == 0));
            chk("m_busy",   BUSY,     (busy_left != 0));
            chk("m_sp",     dbg_sp,   n);
            chk("m_ram_en", RAM_EN,   e_en);
            chk("m_ram_we", RAM_WE,   e_we);
            chk("m_ram_ad", RAM_ADDR, e_addr);
            chk("m_ram_di", RAM_DIN,  e_din);
            chk("m_ram_rs", RAM_RST,  RST);
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge. The task then returns
    // at the falling edge, where the caller checks the outputs.
    task automatic drive(input logic r, input logic p, input logic o,
                         input logic k, input logic [7:0] d);
        @(posedge CLK);
        #1;
        RST = r; PUSH = p; POP = o; PEEK = k; Din = d;
        @(negedge CLK);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic push(input logic [7:0] d);
        drive(1'b0, 1'b1, 1'b0, 1'b0, d);
        chk("push_we", RAM_WE, 1'b1);
    endtask

    // Issues a pop (or peek) and expects the data exactly 3 cycles later.
    task automatic read_expect(input logic is_peek, input logic [7:0] exp, input string tag);
        drive(1'b0, 1'b0, !is_peek, is_peek, 8'h00);
        chk({tag, "_en"}, RAM_EN, 1'b1);
        chk({tag, "_we"}, RAM_WE, 1'b0);
        idle();
        chk({tag, "_dv1"}, DVALID, 1'b0);
        chk({tag, "_busy1"}, BUSY, 1'b1);
        idle();
        chk({tag, "_dv2"}, DVALID, 1'b0);
        idle();
        chk({tag, "_dv3"}, DVALID, 1'b1);
        chk({tag, "_dout"}, Dout, exp);
        chk({tag, "_busy3"}, BUSY, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_ramrst", RAM_RST, 1'b1);
        chk("rst_empty", EMPTY, 1'b1);
        chk("rst_full", FULL, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_dout", Dout, 8'h00);
        chk("rst_state", dbg_state, 2'd0);

        // First push after reset goes to address 0.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);
        chk("a5_we", RAM_WE, 1'b1);
        chk("a5_en", RAM_EN, 1'b1);
        chk("a5_addr", RAM_ADDR, 8'h00);
        chk("a5_din", RAM_DIN, 8'hA5);
        idle();
        chk("a5_sp", dbg_sp, 9'd1);
        chk("a5_empty", EMPTY, 1'b0);
        read_expect(1'b0, 8'hA5, "pop_a5");

        // LIFO ordering.
        push(8'h11); push(8'h22); push(8'h33);
        read_expect(1'b0, 8'h33, "pop_33");
        read_expect(1'b0, 8'h22, "pop_22");
        read_expect(1'b0, 8'h11, "pop_11");
        chk("lifo_empty", EMPTY, 1'b1);

        // A pop while empty raises ERR and does not touch the RAM.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("pope_en", RAM_EN, 1'b0);
        idle();
        chk("pope_err", ERR, 1'b1);
        chk("pope_dout", Dout, 8'h11);
        idle();
        chk("pope_err_off", ERR, 1'b0);

        // With PUSH and POP together, the push wins.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h44);
        chk("pp_we", RAM_WE, 1'b1);
        chk("pp_addr", RAM_ADDR, 8'h00);
        idle();
        chk("pp_sp", dbg_sp, 9'd1);
        chk("pp_err", ERR, 1'b0);
        chk("pp_busy", BUSY, 1'b0);

        // Fill to capacity, then push once more while full.
        push(8'h55); push(8'h66); push(8'h77);
        idle();
        chk("full_flag", FULL, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
        chk("pushf_en", RAM_EN, 1'b0);
        idle();
        chk("pushf_err", ERR, 1'b1);
        chk("pushf_sp", dbg_sp, 9'd4);
        read_expect(1'b0, 8'h77, "pop_77");

        // Commands presented while busy are ignored.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hAA);
        chk("busy_push_en", RAM_EN, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("busy_pop_en", RAM_EN, 1'b0);
        chk("busy_err", ERR, 1'b0);
        idle();
        chk("busy_dv", DVALID, 1'b1);
        chk("busy_dout", Dout, 8'h66);
        chk("busy_sp", dbg_sp, 9'd2);
        chk("busy_err2", ERR, 1'b0);

        // Reset during RD_WAIT aborts the pop.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("abort_ramrst", RAM_RST, 1'b1);
        idle();
        chk("abort_dv", DVALID, 1'b0);
        chk("abort_busy", BUSY, 1'b0);
        chk("abort_sp", dbg_sp, 9'd0);
        chk("abort_state", dbg_state, 2'd0);
        idle();
        chk("abort_dv2", DVALID, 1'b0);
        chk("abort_dout", Dout, 8'h00);

        // Reset overrides a command presented in the same cycle.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'hBB);
        chk("rstcmd_en", RAM_EN, 1'b0);
        chk("rstcmd_we", RAM_WE, 1'b0);
        idle();
        chk("rstcmd_empty", EMPTY, 1'b1);

`ifdef STACK_PEEK_EN
        push(8'h5A);
        read_expect(1'b1, 8'h5A, "peek_5a");
        chk("peek_sp", dbg_sp, 9'd1);
        read_expect(1'b0, 8'h5A, "pop_5a");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("peeke_en", RAM_EN, 1'b0);
        idle();
        chk("peeke_err", ERR, 1'b1);
`endif

        idle(); idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
